// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer sequencer.
//   state_t : frame sequencing states
//   SPI_RUN / SPI_WAIT : spi_mode encodings that allow a transfer to proceed
//   DIV_MIN : divisor substituted when the programmed divisor is zero
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam int         DIV_MIN  = 2;

endpackage

// File: rtl/spi_halfbit_timer.sv
// Loadable down-counter used to time the ss lead-in and trail-out intervals.
// Ports:
//   PCLK   in   system clock
//   PRESET in   synchronous active-high reset
//   load   in   load `value` into the counter this cycle
//   value  in   W-bit reload value (half an SCLK period in PCLK cycles)
//   expire out  high while the counter holds 1 (last cycle of the interval)
module spi_halfbit_timer #(
  parameter int W = 12
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  // Counts down to zero and parks there; the FSM only looks at it in LEAD/TRAIL.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Master-side SPI frame sequencer: drops ss, waits a half-bit lead-in, enables
// the baud generator, counts 2*DATA_W SCLK edges, waits a half-bit trail-out,
// releases ss and pulses receive_data. Loss of run permission mid-frame kills
// the frame and pulses xfer_abort instead.
// Ports:
//   PCLK, PRESET     clock and synchronous active-high reset
//   spe, mst         SPI enable and master-mode select
//   spi_mode         00 run, 01 wait, 1x stop
//   spiswai          halt SPI while in wait mode
//   send_data        1-cycle frame start request
//   baudratedivisor  PCLK cycles per SCLK period
//   sclk_edge        1-cycle pulse per SCLK edge from the baud generator
//   ss               slave select, active low (registered)
//   baud_en          SCLK generation enable (registered)
//   tip              transfer in progress (registered)
//   receive_data     1-cycle pulse on normal frame completion (registered)
//   xfer_abort       1-cycle pulse when a frame is killed (registered)
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 12,
  parameter int ECNT_W = 5
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             spe,
  input  logic             mst,
  input  logic [1:0]       spi_mode,
  input  logic             spiswai,
  input  logic             send_data,
  input  logic [DIV_W-1:0] baudratedivisor,
  input  logic             sclk_edge,
  output logic             ss,
  output logic             baud_en,
  output logic             tip,
  output logic             receive_data,
  output logic             xfer_abort
);

  localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W - 1);

  // Half an SCLK period, never zero: a zero divisor is treated as DIV_MIN and
  // a divisor of 1 still yields a one-cycle interval.
  function automatic logic [DIV_W-1:0] half_of(input logic [DIV_W-1:0] div);
    logic [DIV_W-1:0] eff;
    logic [DIV_W-1:0] h;
    eff = (div == '0) ? DIV_W'(DIV_MIN) : div;
    h   = eff >> 1;
    return (h == '0) ? DIV_W'(1) : h;
  endfunction

  state_t            state, state_d;
  logic [ECNT_W-1:0] edge_cnt, edge_cnt_d;
  logic              ss_d, baud_en_d, tip_d, receive_d, abort_d;
  logic              run_ok;
  logic              timer_load;
  logic              timer_expire;
  logic [DIV_W-1:0]  half;

  assign run_ok = spe & mst &
                  ((spi_mode == SPI_RUN) | ((spi_mode == SPI_WAIT) & ~spiswai));

  // The divisor is only consumed when the timer is (re)loaded.
  assign half = half_of(baudratedivisor);

  spi_halfbit_timer #(
    .W(DIV_W)
  ) u_timer (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .load  (timer_load),
    .value (half),
    .expire(timer_expire)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      ss           <= 1'b1;
      baud_en      <= 1'b0;
      tip          <= 1'b0;
      receive_data <= 1'b0;
      xfer_abort   <= 1'b0;
    end else begin
      state        <= state_d;
      edge_cnt     <= edge_cnt_d;
      ss           <= ss_d;
      baud_en      <= baud_en_d;
      tip          <= tip_d;
      receive_data <= receive_d;
      xfer_abort   <= abort_d;
    end
  end

  always_comb begin
    state_d    = state;
    edge_cnt_d = edge_cnt;
    ss_d       = ss;
    baud_en_d  = baud_en;
    tip_d      = tip;
    receive_d  = 1'b0;
    abort_d    = 1'b0;
    timer_load = 1'b0;

    // Losing run permission mid-frame wins over any same-cycle advance.
    if ((state inside {LEAD, SHIFT, TRAIL}) && !run_ok) begin
      state_d    = IDLE;
      edge_cnt_d = '0;
      ss_d       = 1'b1;
      baud_en_d  = 1'b0;
      tip_d      = 1'b0;
      abort_d    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ss_d      = 1'b1;
          baud_en_d = 1'b0;
          tip_d     = 1'b0;
          if (send_data && run_ok) begin
            state_d    = LEAD;
            ss_d       = 1'b0;
            timer_load = 1'b1;
          end
        end
        LEAD: begin
          if (timer_expire) begin
            state_d    = SHIFT;
            baud_en_d  = 1'b1;
            tip_d      = 1'b1;
            edge_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (sclk_edge) begin
            edge_cnt_d = edge_cnt + ECNT_W'(1);
            if (edge_cnt == LAST_EDGE) begin
              state_d    = TRAIL;
              baud_en_d  = 1'b0;
              timer_load = 1'b1;
            end
          end
        end
        TRAIL: begin
          if (timer_expire) begin
            state_d   = DONE;
            ss_d      = 1'b1;
            tip_d     = 1'b0;
            receive_d = 1'b1;
          end
        end
        DONE: begin
          // A send_data arriving here is deliberately dropped.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer. Directed stimulus pushes the expected
// frame outcome (done/abort, lead cycles, SCLK edges, trail cycles); a monitor
// measures each frame from the DUT outputs and compares on every completion or
// abort pulse. A small baud-generator model pulses sclk_edge every 2 cycles
// while baud_en is high.
module tb_spi_xfer_sequencer;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 12;
  localparam int ECNT_W = 5;

  logic             PCLK;
  logic             PRESET;
  logic             spe;
  logic             mst;
  logic [1:0]       spi_mode;
  logic             spiswai;
  logic             send_data;
  logic [DIV_W-1:0] baudratedivisor;
  logic             sclk_edge;
  logic             ss;
  logic             baud_en;
  logic             tip;
  logic             receive_data;
  logic             xfer_abort;

  logic stray;

  typedef struct {
    bit abort;
    int lead;
    int edges;
    int trail;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_edges = 0;
  int   mon_lead  = 0;
  int   mon_trail = 0;

  spi_xfer_sequencer #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W),
    .ECNT_W(ECNT_W)
  ) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .spe            (spe),
    .mst            (mst),
    .spi_mode       (spi_mode),
    .spiswai        (spiswai),
    .send_data      (send_data),
    .baudratedivisor(baudratedivisor),
    .sclk_edge      (sclk_edge),
    .ss             (ss),
    .baud_en        (baud_en),
    .tip            (tip),
    .receive_data   (receive_data),
    .xfer_abort     (xfer_abort)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Baud generator model: one SCLK edge every other cycle while enabled,
  // plus any stray pulses the stimulus requests.
  initial begin
    bit phase;
    phase     = 1'b0;
    sclk_edge = 1'b0;
    forever begin
      @(posedge PCLK);
      #2;
      if (baud_en === 1'b1) phase = ~phase;
      else                  phase = 1'b0;
      sclk_edge = ((baud_en === 1'b1) && phase) || (stray === 1'b1);
    end
  end

  // Monitor: measure the frame and check it against the scoreboard on each pulse.
  initial begin
    forever begin : mon
      exp_t e;
      @(negedge PCLK);
      if (PRESET === 1'b1) begin
        mon_edges = 0; mon_lead = 0; mon_trail = 0;
      end else if (receive_data === 1'b1 || xfer_abort === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got receive_data=%0b xfer_abort=%0b required no pulse",
                   receive_data, xfer_abort);
        end else begin
          e = sb.pop_front();
          chk("event_xfer_abort", int'(xfer_abort), int'(e.abort));
          chk("event_receive_data", int'(receive_data), int'(!e.abort));
          chk("frame_lead_cycles", mon_lead, e.lead);
          chk("frame_sclk_edges", mon_edges, e.edges);
          chk("frame_trail_cycles", mon_trail, e.trail);
          chk("event_ss_high", int'(ss === 1'b1), 1);
          chk("event_tip_low", int'(tip === 1'b0), 1);
          chk("event_baud_en_low", int'(baud_en === 1'b0), 1);
        end
        mon_edges = 0; mon_lead = 0; mon_trail = 0;
      end else if (ss !== 1'b0) begin
        mon_edges = 0; mon_lead = 0; mon_trail = 0;
      end else if (baud_en === 1'b1) begin
        if (sclk_edge === 1'b1) mon_edges++;
      end else if (tip === 1'b1) begin
        mon_trail++;
      end else begin
        mon_lead++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic push(input bit ab, input int l, input int e, input int t);
    exp_t x;
    x.abort = ab; x.lead = l; x.edges = e; x.trail = t;
    sb.push_back(x);
  endtask

  task automatic send();
    send_data = 1'b1;
    tick(1);
    send_data = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    tick(2);
  endtask

  task automatic wait_edges(input int k, input int budget);
    int n;
    n = 0;
    while (mon_edges < k && n < budget) begin
      tick(1);
      n++;
    end
    chk("edges_reached", int'(mon_edges >= k), 1);
  endtask

  task automatic wait_baud(input int budget);
    int n;
    n = 0;
    while (baud_en !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk("baud_en_seen", int'(baud_en === 1'b1), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ss"}, int'(ss === 1'b1), 1);
    chk({tag, "_baud_en"}, int'(baud_en === 1'b0), 1);
    chk({tag, "_tip"}, int'(tip === 1'b0), 1);
    chk({tag, "_receive_data"}, int'(receive_data === 1'b0), 1);
    chk({tag, "_xfer_abort"}, int'(xfer_abort === 1'b0), 1);
  endtask

  initial begin
    PRESET          = 1'b1;
    spe             = 1'b1;
    mst             = 1'b1;
    spi_mode        = 2'b00;
    spiswai         = 1'b0;
    send_data       = 1'b0;
    stray           = 1'b0;
    baudratedivisor = DIV_W'(4);
    tick(3);
    chk_idle("reset");
    PRESET = 1'b0;
    tick(2);

    // Normal frame, div=4 -> half=2
    push(1'b0, 2, 16, 2);
    send();
    drain("t1_normal", 200);

    // Degenerate divisors both give half=1
    baudratedivisor = DIV_W'(0);
    push(1'b0, 1, 16, 1);
    send();
    drain("t2_div0", 200);
    baudratedivisor = DIV_W'(1);
    push(1'b0, 1, 16, 1);
    send();
    drain("t2_div1", 200);
    baudratedivisor = DIV_W'(4);

    // Abort by spe drop after 5 edges
    push(1'b1, 2, 5, 0);
    send();
    wait_edges(5, 100);
    spe = 1'b0;
    drain("t3_abort_spe", 20);
    spe = 1'b1;

    // Abort by entering wait mode with spiswai set
    push(1'b1, 2, 5, 0);
    send();
    wait_edges(5, 100);
    spi_mode = 2'b01;
    spiswai  = 1'b1;
    drain("t3_abort_wait", 20);
    spi_mode = 2'b00;
    spiswai  = 1'b0;

    // Wait mode without spiswai keeps running
    push(1'b0, 2, 16, 2);
    send();
    wait_edges(5, 100);
    spi_mode = 2'b01;
    drain("t3_wait_runs", 200);
    spi_mode = 2'b00;

    // send_data during SHIFT is ignored and not queued
    push(1'b0, 2, 16, 2);
    send();
    wait_edges(3, 100);
    send();
    drain("t4_send_in_shift", 200);
    tick(6);
    chk("t4_no_queued_frame_ss", int'(ss === 1'b1), 1);

    // Stray sclk_edge pulses in IDLE and LEAD, div=8 -> half=4
    baudratedivisor = DIV_W'(8);
    stray = 1'b1;
    tick(3);
    chk("t4_stray_idle_ss", int'(ss === 1'b1), 1);
    push(1'b0, 4, 16, 4);
    send();
    tick(2);
    stray = 1'b0;
    drain("t4_stray_lead", 200);
    baudratedivisor = DIV_W'(4);

    // send_data with mst=0 or stop mode is ignored
    mst = 1'b0;
    send();
    tick(5);
    chk("t4_mst0_ss", int'(ss === 1'b1), 1);
    chk("t4_mst0_tip", int'(tip === 1'b0), 1);
    mst = 1'b1;
    spi_mode = 2'b10;
    send();
    tick(5);
    chk("t4_stop_ss", int'(ss === 1'b1), 1);
    spi_mode = 2'b00;

    // Reset mid-SHIFT: no pulses, outputs back to reset values
    send();
    wait_baud(50);
    tick(3);
    PRESET = 1'b1;
    tick(1);
    chk_idle("t5_reset");
    PRESET = 1'b0;
    tick(3);
    chk("t5_after_reset_ss", int'(ss === 1'b1), 1);
    push(1'b0, 2, 16, 2);
    send();
    drain("t5_clean_frame", 200);

    // Divisor change during SHIFT affects TRAIL and the next LEAD
    push(1'b0, 2, 16, 4);
    send();
    wait_baud(50);
    baudratedivisor = DIV_W'(8);
    drain("t6_div_change", 200);
    push(1'b0, 4, 16, 4);
    send();
    drain("t6_next_frame", 200);
    baudratedivisor = DIV_W'(4);

    tick(4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
